aqed_resp_checker: RTL
======================

Name: aqed_resp_checker

Overview:
- Sits directly downstream of memory_core in the A-QED formal harness and consumes its output stream (data_out / valid_out), with ready driven back to the core.
- Tracks which accepted output belongs to the original transaction and which to its duplicate, then captures both.
- Raises qed_done with qed_check for the A-QED match property.
- Provides an orig_done flag and a bounded-response watchdog that replace the ad-hoc counters in the harness top.

Parameters:
- DW, 16, data width of the stream.
- IDXW, 16, width of transaction index counters.
- BOUND, 64, max clk_en cycles allowed between orig issue and orig capture before bound_err.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- clk_en  in  1  global enable; when 0 all state holds and ready=0
- acc_valid  in  1  core output valid (valid_out)
- acc_data  in  DW  core output data
- acc_ready  out  1  checker ready (drives ren_in); =clk_en & ~hold_in
- hold_in  in  1  solver-driven backpressure
- orig_issue  in  1  pulse: upstream issued original input with index orig_idx
- orig_idx  in  IDXW  input-stream index of original
- dup_issue  in  1  pulse: upstream issued duplicate with index dup_idx
- dup_idx  in  IDXW  input-stream index of duplicate
- out_count  out  IDXW  number of accepted outputs
- orig_issued  out  1  original index registered
- orig_done  out  1  original output captured (sticky)
- qed_done  out  1  duplicate output captured (sticky)
- qed_check  out  1  captured outputs equal (valid when qed_done)
- bound_err  out  1  sticky watchdog violation

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; out_count=0; all flags 0; capture regs 0. Reset mid-operation discards all state in one cycle.
- Accept: fire = acc_valid & acc_ready. out_count increments on fire and saturates at 2^IDXW-1 (no wrap). Output k corresponds to input k (in-order core).
- Registration of orig_issue and dup_issue is gated by clk_en: issue pulses with clk_en=0 are ignored.
- FSM states IDLE, WAIT_ORIG, WAIT_DUP, DONE.
- IDLE:
  - orig_issue -> latch orig_idx, orig_issued=1, go to WAIT_ORIG.
  - dup_issue in IDLE is ignored.
- WAIT_ORIG:
  - dup_issue latches dup_idx (dup_pend=1) in any non-IDLE state, first occurrence only. dup_idx <= orig_idx is treated as malformed: ignored.
  - fire with out_count==orig_idx -> orig_data<=acc_data, orig_done=1, go to WAIT_DUP.
  - If out_count already > orig_idx at registration time, set bound_err and go to DONE with qed_done=0.
- WAIT_DUP: fire with dup_pend & out_count==dup_idx -> dup_data<=acc_data, go to DONE next cycle.
- Same-cycle events:
  - orig_issue and fire in the same cycle: the issue registers first, so the fire is compared against the new orig_idx next cycle only.
  - dup_issue and fire: the dup latches this cycle; the compare starts next cycle.
- DONE: qed_done=1, qed_check=(orig_data==dup_data). Both sticky until reset. Further orig_issue/dup_issue ignored; out_count keeps counting.
- Latency: orig_done asserts 1 cycle after capturing fire; qed_done/qed_check 1 cycle after dup capture.
- Watchdog: a counter of clk_en cycles runs in WAIT_ORIG. Reaching BOUND sets bound_err (sticky); the FSM continues.
- qed_check is 0 whenever qed_done is 0.

Test Plan:
- Reset low 2 cycles with acc_valid=1 -> out_count=0, all flags 0, acc_ready=0 while clk_en=0.
- orig_issue idx=2, dup_issue idx=5, stream 0x10..0x15 with data[2]=data[5]=0xAB -> orig_done after 3rd fire; qed_done=1, qed_check=1 one cycle after 6th fire.
- Same as previous but data[5]=0xAC -> qed_done=1, qed_check=0.
- hold_in=1 for 10 cycles mid-stream with orig idx=1 -> acc_ready=0, out_count frozen, capture still equals element 1.
- orig_issue idx=0, acc_valid held 0 for BOUND=64 cycles -> bound_err=1 at cycle 64, qed_done=0.
- Reset asserted one cycle in WAIT_DUP, then new orig=0/dup=1 with equal data -> fresh pass, qed_check=1, no stale capture.

Source files
------------

// File: rtl/aqed_resp_checker.sv
// -----------------------------------------------------------------------------
// aqed_resp_checker
//
// Response-side checker for the A-QED harness. It sits directly after the
// memory core, accepts the core's in-order output stream and works out which
// accepted output belongs to the original transaction and which to its
// duplicate. Both are captured. Once the duplicate is captured, qed_done rises
// and qed_check reports whether the two captures are equal. A bounded-response
// watchdog flags an original whose output does not arrive in time.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   clk_en          global enable; when low all state holds and acc_ready=0
//   acc_valid/data  core output stream (valid_out / data_out)
//   acc_ready       checker ready back to the core (= clk_en & ~hold_in)
//   hold_in         solver-driven backpressure
//   orig_issue/idx  upstream issued the original with input-stream index idx
//   dup_issue/idx   upstream issued the duplicate with input-stream index idx
//   out_count       number of accepted outputs (saturating)
//   orig_issued     original index has been registered
//   orig_done       original output captured (sticky)
//   qed_done        duplicate output captured (sticky)
//   qed_check       captured outputs equal (0 while qed_done is 0)
//   bound_err       sticky watchdog / late-registration violation
// -----------------------------------------------------------------------------
module aqed_resp_checker #(
  parameter int DW    = 16,
  parameter int IDXW  = 16,
  parameter int BOUND = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            acc_valid,
  input  logic [DW-1:0]   acc_data,
  output logic            acc_ready,
  input  logic            hold_in,
  input  logic            orig_issue,
  input  logic [IDXW-1:0] orig_idx,
  input  logic            dup_issue,
  input  logic [IDXW-1:0] dup_idx,
  output logic [IDXW-1:0] out_count,
  output logic            orig_issued,
  output logic            orig_done,
  output logic            qed_done,
  output logic            qed_check,
  output logic            bound_err
);

  localparam int WDW = $clog2(BOUND + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ORIG, WAIT_DUP, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] out_count_q, out_count_d;
  logic [IDXW-1:0] orig_idx_q, orig_idx_d;
  logic [IDXW-1:0] dup_idx_q, dup_idx_d;
  logic            dup_pend_q, dup_pend_d;
  logic            orig_issued_q, orig_issued_d;
  logic            orig_done_q, orig_done_d;
  logic            qed_done_q, qed_done_d;
  logic            bound_err_q, bound_err_d;
  logic [DW-1:0]   orig_data_q, orig_data_d;
  logic [DW-1:0]   dup_data_q, dup_data_d;
  logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
  logic            fire;

  assign acc_ready = clk_en & ~hold_in;
  assign fire      = acc_valid & acc_ready;

  always_comb begin
    state_d       = state_q;
    out_count_d   = out_count_q;
    orig_idx_d    = orig_idx_q;
    dup_idx_d     = dup_idx_q;
    dup_pend_d    = dup_pend_q;
    orig_issued_d = orig_issued_q;
    orig_done_d   = orig_done_q;
    qed_done_d    = qed_done_q;
    bound_err_d   = bound_err_q;
    orig_data_d   = orig_data_q;
    dup_data_d    = dup_data_q;
    wd_cnt_d      = wd_cnt_q;

    // Everything, including issue registration, is frozen while clk_en is low.
    if (clk_en) begin
      // out_count is the index of the output currently on the bus; it
      // saturates rather than wrapping so a long run can never alias index 0.
      if (fire && (out_count_q != {IDXW{1'b1}})) begin
        out_count_d = out_count_q + 1'b1;
      end

      // Only the first well-formed duplicate is kept. A duplicate that does
      // not follow the original in the input stream is malformed and dropped.
      if (dup_issue && !dup_pend_q &&
          ((state_q == WAIT_ORIG) || (state_q == WAIT_DUP)) &&
          (dup_idx > orig_idx_q)) begin
        dup_idx_d  = dup_idx;
        dup_pend_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          // The compare against the new index only begins next cycle, so a
          // fire in this same cycle is never matched against orig_idx.
          if (orig_issue) begin
            orig_idx_d    = orig_idx;
            orig_issued_d = 1'b1;
            wd_cnt_d      = '0;
            if (out_count_q > orig_idx) begin
              // The original's output already went by: it can never be caught.
              bound_err_d = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = WAIT_ORIG;
            end
          end
        end

        WAIT_ORIG: begin
          if (fire && (out_count_q == orig_idx_q)) begin
            orig_data_d = acc_data;
            orig_done_d = 1'b1;
            state_d     = WAIT_DUP;
          end else begin
            // The error fires on the BOUND-th enabled cycle without capture;
            // the counter then parks at BOUND so it raises the flag only once.
            if (wd_cnt_q == WDW'(BOUND - 1)) begin
              bound_err_d = 1'b1;
            end
            if (wd_cnt_q != WDW'(BOUND)) begin
              wd_cnt_d = wd_cnt_q + 1'b1;
            end
          end
        end

        WAIT_DUP: begin
          if (dup_pend_q && fire && (out_count_q == dup_idx_q)) begin
            dup_data_d = acc_data;
            qed_done_d = 1'b1;
            state_d    = DONE;
          end
        end

        DONE: begin
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      out_count_q   <= '0;
      orig_idx_q    <= '0;
      dup_idx_q     <= '0;
      dup_pend_q    <= 1'b0;
      orig_issued_q <= 1'b0;
      orig_done_q   <= 1'b0;
      qed_done_q    <= 1'b0;
      bound_err_q   <= 1'b0;
      orig_data_q   <= '0;
      dup_data_q    <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      out_count_q   <= out_count_d;
      orig_idx_q    <= orig_idx_d;
      dup_idx_q     <= dup_idx_d;
      dup_pend_q    <= dup_pend_d;
      orig_issued_q <= orig_issued_d;
      orig_done_q   <= orig_done_d;
      qed_done_q    <= qed_done_d;
      bound_err_q   <= bound_err_d;
      orig_data_q   <= orig_data_d;
      dup_data_q    <= dup_data_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign out_count   = out_count_q;
  assign orig_issued = orig_issued_q;
  assign orig_done   = orig_done_q;
  assign qed_done    = qed_done_q;
  // A late-registration DONE has qed_done low, so the check is masked there too.
  assign qed_check   = qed_done_q & (orig_data_q == dup_data_q);
  assign bound_err   = bound_err_q;

endmodule
